// File: rtl/stack_reg_unit.sv
// stack_reg_unit
//   Holds the architectural eip/ebp/esp registers and applies the
//   stack-pointer side effects of decoded stack/flow ops (NOP, PUSH, POP,
//   CALL, RET, ENTER, LEAVE, JMP). It also merges ALU writeback into esp/ebp.
//   LEAVE is the only two-cycle op; its second cycle is the LEAVE2 state.
//
//   Optional feature: define STACK_LIMIT_EN to enable stack bound checking.
//   A PUSH/CALL whose (esp-4) is below STACK_LIMIT is suppressed, and so is a
//   POP/RET/LEAVE2 whose (esp+4) is above RESET_ESP. A suppressed op sets
//   stack_fault, which stays set until reset.
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   cmd_valid    in   1   decode presents a command
//   cmd_ready    out  1   command can be accepted (IDLE only)
//   cmd_op       in   3   0 NOP,1 PUSH,2 POP,3 CALL,4 RET,5 ENTER,6 LEAVE,7 JMP
//   instr_len    in   4   instruction length added to eip
//   target       in   32  CALL/JMP target
//   mem_rdata    in   32  stack word at [esp] (RET address / LEAVE saved ebp)
//   wb_en        in   1   ALU writeback strobe
//   wb_sel       in   4   4'h1/4'h4 esp, 4'h2 ebp, others ignored
//   wb_data      in   32  writeback value
//   eip/ebp/esp  out  32  architectural registers
//   busy         out  1   high during LEAVE2
//   wb_lost      out  1   one-cycle pulse: writeback lost to a command
//   stack_fault  out  1   sticky bound violation (constant 0 without macro)
module stack_reg_unit #(
   parameter logic [31:0] RESET_EIP   = 32'h0000_0000,
   parameter logic [31:0] RESET_ESP   = 32'h0000_1000,
   parameter logic [31:0] STACK_LIMIT = 32'h0000_0800
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [3:0]  instr_len,
   input  logic [31:0] target,
   input  logic [31:0] mem_rdata,
   input  logic        wb_en,
   input  logic [3:0]  wb_sel,
   input  logic [31:0] wb_data,
   output logic [31:0] eip,
   output logic [31:0] ebp,
   output logic [31:0] esp,
   output logic        busy,
   output logic        wb_lost,
   output logic        stack_fault
);

`ifdef STACK_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   typedef enum logic {IDLE, LEAVE2} state_e;
   typedef enum logic [2:0] {
      OP_NOP, OP_PUSH, OP_POP, OP_CALL, OP_RET, OP_ENTER, OP_LEAVE, OP_JMP
   } op_e;

   state_e      state_q, state_n;
   logic [31:0] eip_q, eip_n, esp_q, esp_n, ebp_q, ebp_n;
   logic [3:0]  len_q, len_n;
   logic        lost_q, lost_n, fault_q, fault_n;
   logic        cmd_esp, cmd_ebp;
   logic [31:0] esp_dec, esp_inc, eip_adv;
   logic        fault_dec, fault_inc;
   op_e         op;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         eip_q   <= RESET_EIP;
         esp_q   <= RESET_ESP;
         ebp_q   <= RESET_ESP;
         len_q   <= '0;
         lost_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_n;
         eip_q   <= eip_n;
         esp_q   <= esp_n;
         ebp_q   <= ebp_n;
         len_q   <= len_n;
         lost_q  <= lost_n;
         fault_q <= fault_n;
      end
   end

   always_comb begin
      state_n = state_q;
      eip_n   = eip_q;
      esp_n   = esp_q;
      ebp_n   = ebp_q;
      len_n   = len_q;
      lost_n  = 1'b0;
      fault_n = fault_q;
      cmd_esp = 1'b0;
      cmd_ebp = 1'b0;
      op      = op_e'(cmd_op);
      esp_dec = esp_q - 32'd4;
      esp_inc = esp_q + 32'd4;
      eip_adv = eip_q + {28'd0, instr_len};
      fault_dec = LIMIT_EN && (esp_dec < STACK_LIMIT);
      fault_inc = LIMIT_EN && (esp_inc > RESET_ESP);

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               case (op)
                  OP_NOP: eip_n = eip_adv;
                  OP_PUSH, OP_CALL: begin
                     if (fault_dec) fault_n = 1'b1;
                     else begin
                        esp_n   = esp_dec;
                        eip_n   = (op == OP_CALL) ? target : eip_adv;
                        cmd_esp = 1'b1;
                     end
                  end
                  OP_POP, OP_RET: begin
                     if (fault_inc) fault_n = 1'b1;
                     else begin
                        esp_n   = esp_inc;
                        eip_n   = (op == OP_RET) ? mem_rdata : eip_adv;
                        cmd_esp = 1'b1;
                     end
                  end
                  OP_ENTER: begin
                     ebp_n   = esp_q;
                     eip_n   = eip_adv;
                     cmd_ebp = 1'b1;
                  end
                  OP_LEAVE: begin
                     esp_n   = ebp_q;
                     len_n   = instr_len;
                     state_n = LEAVE2;
                     cmd_esp = 1'b1;
                  end
                  OP_JMP: eip_n = target;
                  default: ;
               endcase
            end
         end
         LEAVE2: begin
            state_n = IDLE;
            if (fault_inc) fault_n = 1'b1;
            else begin
               ebp_n   = mem_rdata;
               esp_n   = esp_inc;
               eip_n   = eip_q + {28'd0, len_q};
               cmd_esp = 1'b1;
               cmd_ebp = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Writeback loses to a command or LEAVE2 that writes the same register in this cycle.
      if (wb_en) begin
         case (wb_sel)
            4'h1, 4'h4: begin
               if (cmd_esp) lost_n = 1'b1;
               else         esp_n  = wb_data;
            end
            4'h2: begin
               if (cmd_ebp) lost_n = 1'b1;
               else         ebp_n  = wb_data;
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign busy        = (state_q == LEAVE2);
   assign eip         = eip_q;
   assign esp         = esp_q;
   assign ebp         = ebp_q;
   assign wb_lost     = lost_q;
   assign stack_fault = fault_q;

endmodule

// File: tb/tb_stack_reg_unit.sv
// tb_stack_reg_unit
//   Directed bench for stack_reg_unit with hand-computed expected values.
//   Expectations for the bound-check case follow STACK_LIMIT_EN if it is defined.
module tb_stack_reg_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [3:0]  instr_len;
   logic [31:0] target;
   logic [31:0] mem_rdata;
   logic        wb_en;
   logic [3:0]  wb_sel;
   logic [31:0] wb_data;
   logic [31:0] eip, ebp, esp;
   logic        busy, wb_lost, stack_fault;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   stack_reg_unit #(
      .RESET_EIP  (32'h0000_0000),
      .RESET_ESP  (32'h0000_1000),
      .STACK_LIMIT(32'h0000_0800)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .instr_len  (instr_len),
      .target     (target),
      .mem_rdata  (mem_rdata),
      .wb_en      (wb_en),
      .wb_sel     (wb_sel),
      .wb_data    (wb_data),
      .eip        (eip),
      .ebp        (ebp),
      .esp        (esp),
      .busy       (busy),
      .wb_lost    (wb_lost),
      .stack_fault(stack_fault)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive one cycle of stimulus, clock it in, then sample 1 time unit after the edge.
   task automatic issue(input logic v, input logic [2:0] op, input logic [3:0] len,
                        input logic [31:0] tgt, input logic [31:0] mem,
                        input logic we, input logic [3:0] sel, input logic [31:0] wd);
      cmd_valid = v;   cmd_op = op;   instr_len = len; target = tgt;
      mem_rdata = mem; wb_en = we;    wb_sel = sel;    wb_data = wd;
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
      wb_en     = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      cmd_valid = 1'b0; cmd_op = '0; instr_len = '0; target = '0;
      mem_rdata = '0; wb_en = 1'b0; wb_sel = '0; wb_data = '0;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock); #1;
      check("rst_eip", eip, 32'h0);
      check("rst_esp", esp, 32'h1000);
      check("rst_ebp", ebp, 32'h1000);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_wblost", {31'd0, wb_lost}, 32'd0);
      check("rst_fault", {31'd0, stack_fault}, 32'd0);

      issue(1'b1, 3'd1, 4'd2, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);   // PUSH
      check("push_esp", esp, 32'hFFC);
      check("push_eip", eip, 32'h2);
      issue(1'b1, 3'd2, 4'd1, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);   // POP
      check("pop_esp", esp, 32'h1000);
      check("pop_eip", eip, 32'h3);

      issue(1'b1, 3'd3, 4'd3, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0);  // CALL
      check("call_eip", eip, 32'h40);
      check("call_esp", esp, 32'hFFC);
      issue(1'b1, 3'd4, 4'd1, 32'h0, 32'h3, 1'b0, 4'h0, 32'h0);   // RET
      check("ret_eip", eip, 32'h3);
      check("ret_esp", esp, 32'h1000);

      issue(1'b1, 3'd7, 4'd5, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0); // JMP
      check("jmp_eip", eip, 32'h100);
      check("jmp_esp", esp, 32'h1000);
      issue(1'b1, 3'd0, 4'd15, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);  // NOP len 15
      check("nop_eip", eip, 32'h10F);

      issue(1'b1, 3'd5, 4'd1, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);   // ENTER
      check("enter_ebp", ebp, 32'h1000);
      check("enter_eip", eip, 32'h110);
      issue(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'h1, 32'hF00); // wb esp
      check("wb_esp", esp, 32'hF00);
      check("wb_nolost", {31'd0, wb_lost}, 32'd0);
      issue(1'b1, 3'd5, 4'd2, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);   // ENTER
      check("enter2_ebp", ebp, 32'hF00);
      check("enter2_eip", eip, 32'h112);

      // LEAVE; a PUSH held on cmd_valid during LEAVE2 must not take effect.
      issue(1'b1, 3'd6, 4'd1, 32'h0, 32'h1000, 1'b0, 4'h0, 32'h0);
      check("leave1_esp", esp, 32'hF00);
      check("leave1_ebp", ebp, 32'hF00);
      check("leave1_ready", {31'd0, cmd_ready}, 32'd0);
      check("leave1_busy", {31'd0, busy}, 32'd1);
      check("leave1_eip", eip, 32'h112);
      issue(1'b1, 3'd1, 4'd7, 32'h0, 32'h1000, 1'b0, 4'h0, 32'h0);
      check("leave2_ebp", ebp, 32'h1000);
      check("leave2_esp", esp, 32'hF04);
      check("leave2_eip", eip, 32'h113);
      check("leave2_busy", {31'd0, busy}, 32'd0);
      check("leave2_ready", {31'd0, cmd_ready}, 32'd1);

      issue(1'b1, 3'd1, 4'd0, 32'h0, 32'h0, 1'b1, 4'h1, 32'h5555); // PUSH + wb esp
      check("clash_esp", esp, 32'hF00);
      check("clash_lost", {31'd0, wb_lost}, 32'd1);
      issue(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      check("lost_pulse_end", {31'd0, wb_lost}, 32'd0);
      issue(1'b1, 3'd1, 4'd1, 32'h0, 32'h0, 1'b1, 4'h2, 32'h2000); // PUSH + wb ebp
      check("side_esp", esp, 32'hEFC);
      check("side_ebp", ebp, 32'h2000);
      check("side_lost", {31'd0, wb_lost}, 32'd0);
      check("side_eip", eip, 32'h114);

      issue(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'h8, 32'h1234); // invalid sel
      check("badsel_esp", esp, 32'hEFC);
      check("badsel_ebp", ebp, 32'h2000);
      check("badsel_lost", {31'd0, wb_lost}, 32'd0);
      issue(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'h4, 32'h800);  // wb esp via 4'h4
      check("wb4_esp", esp, 32'h800);

      issue(1'b1, 3'd1, 4'd1, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);   // PUSH at limit
`ifdef STACK_LIMIT_EN
      check("limit_esp", esp, 32'h800);
      check("limit_eip", eip, 32'h114);
      check("limit_fault", {31'd0, stack_fault}, 32'd1);
      issue(1'b1, 3'd0, 4'd1, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      check("fault_sticky", {31'd0, stack_fault}, 32'd1);
`else
      check("limit_esp", esp, 32'h7FC);
      check("limit_eip", eip, 32'h115);
      check("limit_fault", {31'd0, stack_fault}, 32'd0);
`endif

      // Reset while in LEAVE2.
      issue(1'b1, 3'd6, 4'd3, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      check("pre_rst_esp", esp, 32'h2000);
      #2 reset_n = 1'b0;
      #1;
      check("arst_eip", eip, 32'h0);
      check("arst_esp", esp, 32'h1000);
      check("arst_ebp", ebp, 32'h1000);
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_ready", {31'd0, cmd_ready}, 32'd1);
      check("arst_fault", {31'd0, stack_fault}, 32'd0);
      @(posedge clock); #1 reset_n = 1'b1;
      issue(1'b0, 3'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      check("post_rst_esp", esp, 32'h1000);
      check("post_rst_ebp", ebp, 32'h1000);
      check("post_rst_eip", eip, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
